alu_ctl_md: RTL
===============

# alu_ctl_md

Parametrised ALU control and multi-cycle multiply/divide sequencer for the EX stage. It widens the ALU control code to cover every RV32I R-type and I-type arithmetic operation. It also decodes the RV32M extension (funct7 = 0000001) and runs an iterative XLEN-cycle multiply or divide. While that operation runs, it stalls the pipeline through a busy/done handshake.

## Interface
Parameters:
- XLEN, 32, operand/result width (≥ 8, power of two)
- CTL_W, 4, width of o_alu_ctl

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous active-high reset
- i_alu_op  in  2  ALU_OP_ADD / ALU_OP_SUB / ALU_OP_U_TYPE / ALU_OP_SPECIAL
- i_op_imm  in  1  1 = I-type arithmetic, 0 = R-type (qualifies funct7 use)
- i_f3  in  3  funct3
- i_f7  in  7  funct7
- i_valid  in  1  EX holds a valid instruction
- i_flush  in  1  EX instruction killed this cycle
- i_rs1, i_rs2  in  XLEN each  operands
- o_alu_ctl  out  CTL_W  single-cycle ALU control code
- o_is_md  out  1  current instruction is an M-extension op
- o_md_busy  out  1  stall request to the pipeline
- o_md_done  out  1  o_md_result valid this cycle
- o_md_result  out  XLEN  multiply/divide result
- o_illegal  out  1  M op decoded but not supported in this build

## Operation
- Decode (combinational):
  - ALU_OP_ADD → ADD.
  - ALU_OP_SUB → SUB.
  - ALU_OP_U_TYPE → U_EXT.
  - ALU_OP_SPECIAL decodes by funct3:
    - 000 → SUB only when !i_op_imm & i_f7[5], else ADD.
    - 001 → SLL.
    - 010 → SLT.
    - 011 → SLTU.
    - 100 → XOR.
    - 101 → SRA if i_f7[5], else SRL.
    - 110 → OR.
    - 111 → AND.
- M-op detection: o_is_md = (i_alu_op == ALU_OP_SPECIAL) & !i_op_imm & (i_f7 == 7'b0000001). When o_is_md is high, o_alu_ctl = ADD (don't-care to the ALU).
- M-op codes by funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states and transitions:
  - IDLE: if i_valid & o_is_md & !i_flush & !o_illegal, latch operands and op, clear counter → BUSY.
  - BUSY: one iteration per cycle, counter increments. When counter == XLEN-1 → DONE. i_flush → IDLE.
  - DONE: o_md_done = 1, result held. → IDLE unconditionally. i_flush in DONE is ignored; the pipeline discards the result.
- Multiply algorithm:
  - Shift-add on absolute values into a 2·XLEN accumulator, sign-corrected at DONE.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide algorithm:
  - Restoring division on absolute values.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
- Divide boundary cases:
  - Divide by zero: quotient = all ones, remainder = rs1 (no trap).
  - Signed overflow (rs1 = −2^(XLEN−1), rs2 = −1): quotient = rs1, remainder = 0.
  - Both special cases still take the full XLEN iterations, so latency is fixed.
- Operand capture: operands are captured in IDLE. Later changes on i_rs1/i_rs2 are ignored.

## Timing
- o_md_busy:
  - IDLE: i_valid & o_is_md & !o_illegal (combinational, same cycle the instruction arrives).
  - BUSY: 1.
  - DONE: 0.
- Latency: instruction arrives at cycle 0. BUSY covers cycles 1..XLEN. DONE is cycle XLEN+1. The stall lasts XLEN+1 cycles, and the pipeline advances at the end of DONE.
- Back-to-back: a new M op presented in the cycle after DONE starts normally. There are no dead cycles beyond DONE.
- Reset values: state = IDLE, counter = 0, o_md_busy = 0, o_md_done = 0, o_md_result = 0. o_alu_ctl, o_is_md and o_illegal are combinational.
- Reset mid-operation: i_rst overrides i_flush and all transitions. IDLE is reached on the next edge and no done pulse is issued.

## Configuration
- MULDIV_DIV_EN:
  - Defined: all eight M ops are supported.
  - Undefined: divider datapath is removed. M ops with f3[2] = 1 give o_illegal = 1 (combinational) and never enter BUSY, and o_md_busy stays 0 for them. Multiply ops are unaffected.

## Structure
- Constants.vh holds:
  - ALU_OP_* codes.
  - ALU_CTL_* at CTL_W bits: ADD 0, SUB 1, AND 2, OR 3, SLT 4, U_EXT 5, XOR 6, SLL 7, SRL 8, SRA 9, SLTU 10.
  - MD_* funct3 codes.
  - FSM state encodings.
- Sub-module muldiv_iter holds the accumulator, counter and per-iteration shift/add/subtract. The top keeps the decode, FSM and handshake.

## Test plan
- R-type decode: f3 = 000 / f7 = 0100000 → SUB. I-type f3 = 000 with f7 bits = 0100000 → ADD. f3 = 101, f7[5] = 1 → SRA.
- MUL 7 × −3 → result 0xFFFFFFEB. o_md_busy high for 33 cycles, o_md_done single pulse at cycle 33.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000.
- DIV −7 / 2 → −3 and REM −7 / 2 → −1. DIV x / 0 → 0xFFFFFFFF, REMU 5 / 0 → 5. DIV 0x80000000 / −1 → 0x80000000.
- Flush at BUSY cycle 10 → IDLE next edge, no done pulse. A new MUL issued immediately afterwards completes correctly. i_rst mid-BUSY gives the same result.
- Build without MULDIV_DIV_EN: DIVU → o_illegal = 1, o_md_busy = 0. MULHSU still completes.

Source files
------------

// File: rtl/alu_ctl_md_pkg.sv
// alu_ctl_md_pkg: shared constants and types for the EX-stage ALU control
// decoder and the iterative multiply/divide sequencer.
//   - ALU_OP_*   : 2-bit ALU operation class driven by the main decoder
//   - ALU_CTL_*  : single-cycle ALU control codes (cast to CTL_W by users)
//   - md_op_e    : M-extension op, encoded exactly as its funct3
//   - md_state_e : sequencer FSM states
package alu_ctl_md_pkg;

    localparam logic [1:0] ALU_OP_ADD     = 2'd0;
    localparam logic [1:0] ALU_OP_SUB     = 2'd1;
    localparam logic [1:0] ALU_OP_U_TYPE  = 2'd2;
    localparam logic [1:0] ALU_OP_SPECIAL = 2'd3;

    localparam int ALU_CTL_ADD   = 0;
    localparam int ALU_CTL_SUB   = 1;
    localparam int ALU_CTL_AND   = 2;
    localparam int ALU_CTL_OR    = 3;
    localparam int ALU_CTL_SLT   = 4;
    localparam int ALU_CTL_U_EXT = 5;
    localparam int ALU_CTL_XOR   = 6;
    localparam int ALU_CTL_SLL   = 7;
    localparam int ALU_CTL_SRL   = 8;
    localparam int ALU_CTL_SRA   = 9;
    localparam int ALU_CTL_SLTU  = 10;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Bit 2 set = divide family, bit 1 within divides selects remainder.
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Operation latched at start: op plus the sign to apply to the
    // product / quotient once the magnitude iteration is finished.
    typedef struct packed {
        md_op_e op;
        logic   neg;
    } md_ctl_t;

    function automatic logic md_rs1_signed(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_rs2_signed(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/alu_ctl_md_if.sv
// alu_ctl_md_if: EX-stage <-> ALU control / mul-div sequencer bundle.
//   master : pipeline side (drives decode fields, operands, valid/flush)
//   slave  : alu_ctl_md (drives ALU control, M-op status and result)
interface alu_ctl_md_if #(
    parameter int XLEN  = 32,
    parameter int CTL_W = 4
);
    logic [1:0]       i_alu_op;
    logic             i_op_imm;
    logic [2:0]       i_f3;
    logic [6:0]       i_f7;
    logic             i_valid;
    logic             i_flush;
    logic [XLEN-1:0]  i_rs1;
    logic [XLEN-1:0]  i_rs2;
    logic [CTL_W-1:0] o_alu_ctl;
    logic             o_is_md;
    logic             o_md_busy;
    logic             o_md_done;
    logic [XLEN-1:0]  o_md_result;
    logic             o_illegal;

    modport master (
        output i_alu_op, i_op_imm, i_f3, i_f7, i_valid, i_flush, i_rs1, i_rs2,
        input  o_alu_ctl, o_is_md, o_md_busy, o_md_done, o_md_result, o_illegal
    );

    modport slave (
        input  i_alu_op, i_op_imm, i_f3, i_f7, i_valid, i_flush, i_rs1, i_rs2,
        output o_alu_ctl, o_is_md, o_md_busy, o_md_done, o_md_result, o_illegal
    );
endinterface

// File: rtl/alu_ctl_md_muldiv_iter.sv
// alu_ctl_md_muldiv_iter: XLEN-step multiply/divide datapath.
// Holds the 2*XLEN accumulator, the iteration counter and the sign-corrected
// result register. Works on operand magnitudes; signs are applied on the
// final step.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load operands/op, clear counter
//   step      : perform one iteration (counter increments)
//   op,rs1,rs2: operation and operands sampled on start
//   last      : counter is at XLEN-1 (current step is the final one)
//   result    : sign-corrected result, updated on the final step
// Macro MULDIV_DIV_EN: when undefined the restoring-divide path is absent.
module alu_ctl_md_muldiv_iter
    import alu_ctl_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  md_op_e          op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            last,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_nxt, mul_nxt, prod;
    logic [XLEN-1:0]   bmag, res_nxt;
    md_ctl_t           ctl;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum;

    assign a_neg = md_rs1_signed(op) & rs1[XLEN-1];
    assign b_neg = md_rs2_signed(op) & rs2[XLEN-1];
    assign a_mag = a_neg ? -rs1 : rs1;
    assign b_mag = b_neg ? -rs2 : rs2;
    assign last  = (cnt == CW'(XLEN-1));

    // Shift-add: low half holds the remaining multiplier bits, high half
    // the partial product; each step consumes acc[0] and shifts right.
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, bmag} : '0);
    assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

`ifdef MULDIV_DIV_EN
    // Restoring divide: high half = partial remainder, low half = dividend
    // bits shifting out while quotient bits shift in. The shifted remainder
    // needs one extra bit before the trial subtract.
    logic            rneg, b_zero;
    logic [XLEN-1:0] a_raw, q_fix, r_fix;
    logic [XLEN:0]   rem_sh, diff;
    logic            ge;
    logic [2*XLEN-1:0] div_nxt;

    assign rem_sh  = acc[2*XLEN-1:XLEN-1];
    assign diff    = rem_sh - {1'b0, bmag};
    assign ge      = (rem_sh >= {1'b0, bmag});
    assign div_nxt = {(ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], ge};
    assign acc_nxt = ctl.op[2] ? div_nxt : mul_nxt;
`else
    assign acc_nxt = mul_nxt;
`endif

    always_comb begin
        prod    = ctl.neg ? -acc_nxt : acc_nxt;
        res_nxt = (ctl.op == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
        q_fix = ctl.neg ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        r_fix = rneg ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        // Divide by zero: the magnitude loop already yields all-ones, but the
        // sign fix would disturb it, so force the architectural values.
        if (b_zero) begin
            q_fix = '1;
            r_fix = a_raw;
        end
        if (ctl.op[2]) res_nxt = ctl.op[1] ? r_fix : q_fix;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            bmag   <= '0;
            ctl    <= '0;
            result <= '0;
`ifdef MULDIV_DIV_EN
            rneg   <= 1'b0;
            b_zero <= 1'b0;
            a_raw  <= '0;
`endif
        end else if (start) begin
            cnt  <= '0;
            acc  <= {{XLEN{1'b0}}, a_mag};
            bmag <= b_mag;
            ctl  <= '{op: op, neg: a_neg ^ b_neg};
`ifdef MULDIV_DIV_EN
            rneg   <= a_neg;
            b_zero <= (rs2 == '0);
            a_raw  <= rs1;
`endif
        end else if (step) begin
            cnt <= cnt + 1'b1;
            acc <= acc_nxt;
            if (last) result <= res_nxt;
        end
    end

endmodule

// File: rtl/alu_ctl_md.sv
// alu_ctl_md: EX-stage ALU control decode plus multi-cycle RV32M sequencer.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : decode fields, operands, valid/flush in;
//                  ALU control, M-op flag, busy/done handshake, result,
//                  illegal flag out
// Timing: an M op seen in IDLE raises o_md_busy the same cycle, spends XLEN
// cycles in BUSY and pulses o_md_done for one cycle in DONE.
// Macro MULDIV_DIV_EN: defined = all eight M ops; undefined = divide/rem
// ops decode as illegal and never start.
module alu_ctl_md
    import alu_ctl_md_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CTL_W = 4
) (
    input logic          i_clk,
    input logic          i_rst,
    alu_ctl_md_if.slave  bus
);
    md_state_e state;
    logic      md_done;
    logic      is_md, illegal, start, step, last;
    logic [CTL_W-1:0] ctl_sel;

    assign is_md = (bus.i_alu_op == ALU_OP_SPECIAL) & !bus.i_op_imm & (bus.i_f7 == F7_MULDIV);

`ifdef MULDIV_DIV_EN
    assign illegal = 1'b0;
`else
    assign illegal = is_md & bus.i_f3[2];
`endif

    always_comb begin
        ctl_sel = CTL_W'(ALU_CTL_ADD);
        case (bus.i_alu_op)
            ALU_OP_ADD:    ctl_sel = CTL_W'(ALU_CTL_ADD);
            ALU_OP_SUB:    ctl_sel = CTL_W'(ALU_CTL_SUB);
            ALU_OP_U_TYPE: ctl_sel = CTL_W'(ALU_CTL_U_EXT);
            default: begin
                case (bus.i_f3)
                    // I-type has no SUB; its immediate bits must not select it.
                    3'b000: ctl_sel = (!bus.i_op_imm & bus.i_f7[5]) ? CTL_W'(ALU_CTL_SUB)
                                                                    : CTL_W'(ALU_CTL_ADD);
                    3'b001: ctl_sel = CTL_W'(ALU_CTL_SLL);
                    3'b010: ctl_sel = CTL_W'(ALU_CTL_SLT);
                    3'b011: ctl_sel = CTL_W'(ALU_CTL_SLTU);
                    3'b100: ctl_sel = CTL_W'(ALU_CTL_XOR);
                    3'b101: ctl_sel = bus.i_f7[5] ? CTL_W'(ALU_CTL_SRA) : CTL_W'(ALU_CTL_SRL);
                    3'b110: ctl_sel = CTL_W'(ALU_CTL_OR);
                    default: ctl_sel = CTL_W'(ALU_CTL_AND);
                endcase
            end
        endcase
        if (is_md) ctl_sel = CTL_W'(ALU_CTL_ADD);
    end

    assign start = (state == ST_IDLE) & bus.i_valid & is_md & !bus.i_flush & !illegal;
    assign step  = (state == ST_BUSY) & !bus.i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            md_done <= 1'b0;
        end else begin
            md_done <= 1'b0;
            case (state)
                ST_IDLE: if (start) state <= ST_BUSY;
                ST_BUSY: begin
                    if (bus.i_flush) begin
                        state <= ST_IDLE;
                    end else if (last) begin
                        state   <= ST_DONE;
                        md_done <= 1'b1;
                    end
                end
                // Flush here is ignored: the pipeline simply drops the result.
                default: state <= ST_IDLE;
            endcase
        end
    end

    alu_ctl_md_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (i_clk),
        .rst    (i_rst),
        .start  (start),
        .step   (step),
        .op     (md_op_e'(bus.i_f3)),
        .rs1    (bus.i_rs1),
        .rs2    (bus.i_rs2),
        .last   (last),
        .result (bus.o_md_result)
    );

    assign bus.o_alu_ctl = ctl_sel;
    assign bus.o_is_md   = is_md;
    assign bus.o_illegal = illegal;
    assign bus.o_md_done = md_done;
    // Same-cycle stall on arrival so the pipeline never advances past an M op.
    assign bus.o_md_busy = (state == ST_BUSY) |
                           ((state == ST_IDLE) & bus.i_valid & is_md & !illegal);

endmodule
